// File: rtl/dda_pkg.sv
// Shared constants, state encodings and byte-order helpers for the DDA host sequencer.
package dda_pkg;

   localparam logic [7:0] OP_LOAD = 8'h01;
   localparam logic [7:0] OP_RUN  = 8'h02;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] ACK     = 8'hA5;
   localparam logic [7:0] NAK     = 8'hEE;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StAck,
      StCnt,
      StRun,
      StSend
   } ctrl_state_e;

   typedef enum logic [1:0] {
      TxIdle,
      TxReq,
      TxWaitHi,
      TxWaitLo
   } tx_state_e;

   function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

   function automatic logic [7:0] msb_byte(input logic [31:0] w);
      return w[31:24];
   endfunction

endpackage

// File: rtl/dda_frame_tx.sv
// Serializes 1..4 bytes of a 32-bit payload (MSB first) through the UART start/busy handshake.
module dda_frame_tx
   import dda_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  count,
   input  logic [31:0] payload,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   output logic        done
);

   tx_state_e   state_q, state_d;
   logic [31:0] data_q;
   logic [2:0]  left_q;
   logic [1:0]  wait_q;
   logic        advance;
   logic        last;

   assign last = (left_q == 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TxIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TxIdle:   if (start && (count != 3'd0)) state_d = TxReq;
         TxReq:    if (!tx_busy) state_d = TxWaitHi;
         TxWaitHi: begin
            if (tx_busy)      state_d = TxWaitLo;
            else if (advance) state_d = last ? TxIdle : TxReq;
         end
         TxWaitLo: if (advance) state_d = last ? TxIdle : TxReq;
         default:  state_d = TxIdle;
      endcase
   end

   // A transmitter that never raises busy within two cycles of tx_start is treated as done.
   always_comb begin
      advance = 1'b0;
      unique case (state_q)
         TxWaitHi: advance = !tx_busy && (wait_q == 2'd2);
         TxWaitLo: advance = !tx_busy;
         default:  advance = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= 32'h0;
         left_q   <= 3'd0;
         wait_q   <= 2'd0;
         tx_start <= 1'b0;
         tx_byte  <= 8'h00;
         done     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         unique case (state_q)
            TxIdle: begin
               if (start && (count != 3'd0)) begin
                  data_q <= payload;
                  left_q <= count;
               end
            end
            TxReq: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_byte  <= msb_byte(data_q);
                  wait_q   <= 2'd0;
               end
            end
            default: begin
               if (state_q == TxWaitHi) wait_q <= wait_q + 2'd1;
               if (advance) begin
                  data_q <= data_q << 8;
                  left_q <= left_q - 3'd1;
                  done   <= last;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/dda_run_ctrl.sv
// Host command sequencer: parses LOAD/RUN/READ frames, holds the parameter file,
// paces dda_step pulses and streams the DDA state back over the UART.
module dda_run_ctrl
   import dda_pkg::*;
#(
   parameter int unsigned N          = 16,
   parameter int unsigned REG_SIZE   = 10,
   parameter int unsigned STEP_DIV   = 4,
   parameter int unsigned RX_TIMEOUT = 65535
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_valid,
   input  logic [7:0]   rx_byte,
   input  logic         tx_busy,
   output logic         tx_start,
   output logic [7:0]   tx_byte,
   input  logic [N-1:0] v1,
   input  logic [N-1:0] v2,
   output logic         dda_step,
   output logic         dda_load,
   output logic [N-1:0] ic1,
   output logic [N-1:0] ic2,
   output logic [N-1:0] vK_M,
   output logic [N-1:0] vD_M,
   output logic [N-1:0] dt,
   output logic         busy
);

   localparam int unsigned IdxW = $clog2(REG_SIZE);
   localparam int unsigned DivW = $clog2(STEP_DIV + 1);
   localparam int unsigned TmoW = $clog2(RX_TIMEOUT + 1);

   ctrl_state_e     state_q, state_d;
   logic [7:0]      param_q [REG_SIZE];
   logic [IdxW-1:0] idx_q;
   logic            cnt_hi_q;
   logic [15:0]     step_cnt_q;
   logic [DivW-1:0] div_q;
   logic [TmoW-1:0] tmo_q;
   logic [7:0]      reply_q;
   logic            launch_q;
   logic            dda_load_q;

   logic            load_last;
   logic            cnt_last;
   logic            timed_out;
   logic            step_fire;
   logic            tx_done;
   logic [2:0]      tx_count;
   logic [31:0]     tx_payload;

   assign load_last = (state_q == StLoad) && rx_valid && (idx_q == IdxW'(REG_SIZE - 1));
   assign cnt_last  = (state_q == StCnt) && rx_valid && cnt_hi_q;
   assign timed_out = !rx_valid && (tmo_q == TmoW'(RX_TIMEOUT - 1));
   assign step_fire = (div_q == DivW'(STEP_DIV)) && (step_cnt_q != 16'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (rx_valid) begin
               case (rx_byte)
                  OP_LOAD: state_d = StLoad;
                  OP_RUN:  state_d = StCnt;
                  OP_READ: state_d = StSend;
                  default: state_d = StAck;
               endcase
            end
         end
         StLoad: begin
            if (load_last)      state_d = StAck;
            else if (timed_out) state_d = StIdle;
         end
         StCnt: begin
            if (cnt_last)       state_d = StRun;
            else if (timed_out) state_d = StIdle;
         end
         StRun: begin
            if ((step_cnt_q == 16'd0) || (step_fire && (step_cnt_q == 16'd1))) state_d = StSend;
         end
         StAck, StSend: if (tx_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy     = (state_q != StIdle);
      dda_step = (state_q == StRun) && step_fire;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(REG_SIZE); i++) param_q[i] <= 8'h00;
         idx_q      <= '0;
         cnt_hi_q   <= 1'b0;
         step_cnt_q <= 16'd0;
         div_q      <= '0;
         tmo_q      <= '0;
         reply_q    <= 8'h00;
         launch_q   <= 1'b0;
         dda_load_q <= 1'b0;
      end else begin
         // Frame launch is one cycle after entry so SEND captures v1/v2 after the last step.
         launch_q   <= ((state_d == StAck) || (state_d == StSend)) && (state_d != state_q);
         dda_load_q <= load_last;

         if ((state_q == StLoad) || (state_q == StCnt)) begin
            tmo_q <= rx_valid ? '0 : tmo_q + TmoW'(1);
         end else begin
            tmo_q <= '0;
         end

         case (state_q)
            StIdle: begin
               idx_q    <= '0;
               cnt_hi_q <= 1'b0;
               if (rx_valid) reply_q <= NAK;
            end
            StLoad: begin
               if (rx_valid) begin
                  param_q[idx_q] <= rx_byte;
                  idx_q          <= idx_q + IdxW'(1);
               end
               if (load_last) reply_q <= ACK;
            end
            StCnt: begin
               if (rx_valid) begin
                  if (!cnt_hi_q) begin
                     step_cnt_q[15:8] <= rx_byte;
                     cnt_hi_q         <= 1'b1;
                  end else begin
                     step_cnt_q[7:0] <= rx_byte;
                     div_q           <= DivW'(1);
                  end
               end
            end
            StRun: begin
               if (step_fire) begin
                  step_cnt_q <= step_cnt_q - 16'd1;
                  div_q      <= DivW'(1);
               end else begin
                  div_q <= div_q + DivW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_count   = (state_q == StSend) ? 3'd4 : 3'd1;
   assign tx_payload = (state_q == StSend) ? {16'(v1), 16'(v2)} : {reply_q, 24'h0};

   dda_frame_tx u_frame_tx (
      .clk      (clk),
      .rst      (rst),
      .start    (launch_q),
      .count    (tx_count),
      .payload  (tx_payload),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_byte  (tx_byte),
      .done     (tx_done)
   );

   assign dda_load = dda_load_q;
   assign ic1      = N'(be16(param_q[0], param_q[1]));
   assign ic2      = N'(be16(param_q[2], param_q[3]));
   assign vK_M     = N'(be16(param_q[4], param_q[5]));
   assign vD_M     = N'(be16(param_q[6], param_q[7]));
   assign dt       = N'(be16(param_q[8], param_q[9]));

endmodule

// File: tb/tb_dda_run_ctrl.sv
// Self-checking bench for dda_run_ctrl with a UART busy model and a simple DDA stand-in.
module tb_dda_run_ctrl;

   localparam int unsigned STEP_DIV   = 4;
   localparam int unsigned RX_TIMEOUT = 300;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic [15:0] v1, v2;
   logic        dda_step, dda_load, busy;
   logic [15:0] ic1, ic2, vK_M, vD_M, dt;

   dda_run_ctrl #(
      .N          (16),
      .REG_SIZE   (10),
      .STEP_DIV   (STEP_DIV),
      .RX_TIMEOUT (RX_TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_byte  (tx_byte),
      .v1       (v1),
      .v2       (v2),
      .dda_step (dda_step),
      .dda_load (dda_load),
      .ic1      (ic1),
      .ic2      (ic2),
      .vK_M     (vK_M),
      .vD_M     (vD_M),
      .dt       (dt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   int          busy_cnt = 0;
   bit          uart_dead = 1'b0;
   int          total_steps = 0;
   int          total_loads = 0;
   int          n_viol = 0;
   int unsigned last_rx_cyc = 0;
   logic [7:0]  tx_q[$];
   int unsigned step_cyc[$];

   // Reference model state
   logic [7:0]  ref_param [10];
   logic [15:0] ref_v1, ref_v2;

   assign tx_busy = (busy_cnt != 0);

   // UART transmitter stand-in: busy for 10 cycles after each accepted tx_start.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_valid) last_rx_cyc <= cyc;
      if (rst) begin
         busy_cnt <= 0;
      end else if (tx_start) begin
         if (tx_busy) n_viol <= n_viol + 1;
         tx_q.push_back(tx_byte);
         if (!uart_dead) busy_cnt <= 10;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   // DDA stand-in: load takes ic1/ic2, each step adds fixed increments.
   always @(posedge clk) begin
      if (dda_step && dda_load) n_viol <= n_viol + 1;
      if (dda_step) begin
         total_steps <= total_steps + 1;
         step_cyc.push_back(cyc);
      end
      if (dda_load) total_loads <= total_loads + 1;
      if (rst) begin
         v1 <= 16'h1234;
         v2 <= 16'h8001;
      end else if (dda_load) begin
         v1 <= ic1;
         v2 <= ic2;
      end else if (dda_step) begin
         v1 <= v1 + 16'h0001;
         v2 <= v2 + 16'h0101;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_tx(input string tag, input int n, input logic [31:0] word);
      chk({tag, "_txcount"}, tx_q.size(), n);
      for (int i = 0; i < n && i < tx_q.size(); i++) begin
         logic [7:0] e;
         e = 8'(word >> (24 - 8 * i));
         chk($sformatf("%s_txbyte%0d", tag, i), {24'd0, tx_q[i]}, {24'd0, e});
      end
   endtask

   task automatic check_params(input string tag);
      chk({tag, "_ic1"},  ic1,  {ref_param[0], ref_param[1]});
      chk({tag, "_ic2"},  ic2,  {ref_param[2], ref_param[3]});
      chk({tag, "_vkm"},  vK_M, {ref_param[4], ref_param[5]});
      chk({tag, "_vdm"},  vD_M, {ref_param[6], ref_param[7]});
      chk({tag, "_dt"},   dt,   {ref_param[8], ref_param[9]});
   endtask

   task automatic cmd_load(input logic [79:0] p, input int maxgap);
      int l0 = total_loads;
      int s0 = total_steps;
      tx_q.delete();
      send_byte(8'h01, $urandom_range(maxgap, 0));
      for (int i = 0; i < 10; i++) begin
         ref_param[i] = p[79 - 8 * i -: 8];
         send_byte(ref_param[i], (i == 9) ? 0 : $urandom_range(maxgap, 0));
         if (i == 1) chk("load_ic1_early", ic1, {ref_param[0], ref_param[1]});
      end
      ref_v1 = {ref_param[0], ref_param[1]};
      ref_v2 = {ref_param[2], ref_param[3]};
      wait_idle("load");
      check_tx("load", 1, {8'hA5, 24'h0});
      chk("load_pulses", total_loads - l0, 1);
      chk("load_steps", total_steps - s0, 0);
      check_params("load");
   endtask

   task automatic cmd_run(input logic [15:0] n, input int maxgap);
      int s0 = total_steps;
      tx_q.delete();
      step_cyc.delete();
      send_byte(8'h02, $urandom_range(maxgap, 0));
      send_byte(n[15:8], $urandom_range(maxgap, 0));
      send_byte(n[7:0], 0);
      ref_v1 = ref_v1 + n;
      ref_v2 = ref_v2 + 16'(n * 16'h0101);
      wait_idle("run");
      chk("run_steps", total_steps - s0, {16'd0, n});
      if (step_cyc.size() > 0) chk("run_first_gap", step_cyc[0] - last_rx_cyc, STEP_DIV);
      for (int i = 1; i < step_cyc.size(); i++) begin
         chk($sformatf("run_gap%0d", i), step_cyc[i] - step_cyc[i-1], STEP_DIV);
      end
      check_tx("run", 4, {ref_v1, ref_v2});
   endtask

   task automatic cmd_read(input string tag);
      int s0 = total_steps;
      tx_q.delete();
      send_byte(8'h03, 0);
      wait_idle(tag);
      chk({tag, "_steps"}, total_steps - s0, 0);
      check_tx(tag, 4, {ref_v1, ref_v2});
   endtask

   task automatic cmd_bad(input logic [7:0] op);
      int s0 = total_steps;
      int l0 = total_loads;
      tx_q.delete();
      send_byte(op, 0);
      wait_idle("nak");
      check_tx("nak", 1, {8'hEE, 24'h0});
      chk("nak_busy", {31'd0, busy}, 32'd0);
      chk("nak_side_effects", (total_steps - s0) + (total_loads - l0), 0);
   endtask

   initial begin
      logic [79:0] p;
      logic [7:0]  op;
      int          s0;
      int          l0;
      int          k;

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      for (int i = 0; i < 10; i++) ref_param[i] = 8'h00;
      ref_v1 = 16'h1234;
      ref_v2 = 16'h8001;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_strobes", {29'd0, tx_start, dda_step, dda_load}, 32'd0);
      chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
      check_params("rst");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed cases
      cmd_load(80'h0010_0020_0030_0040_0050, 0);
      cmd_run(16'd3, 0);
      cmd_run(16'd0, 0);
      cmd_read("read");
      cmd_bad(8'h7F);

      // Partial LOAD then silence: bytes kept, no ACK, no reload
      tx_q.delete();
      l0 = total_loads;
      send_byte(8'h01, 0);
      ref_param[0] = 8'hAB; ref_param[1] = 8'hCD; ref_param[2] = 8'h12; ref_param[3] = 8'h34;
      for (int i = 0; i < 4; i++) send_byte(ref_param[i], 0);
      repeat (RX_TIMEOUT - 5) @(negedge clk);
      chk("tmo_still_busy", {31'd0, busy}, 32'd1);
      repeat (10) @(negedge clk);
      chk("tmo_idle", {31'd0, busy}, 32'd0);
      chk("tmo_txcount", tx_q.size(), 0);
      chk("tmo_loads", total_loads - l0, 0);
      check_params("tmo");

      // Reset during step 2 of 5
      tx_q.delete();
      s0 = total_steps;
      send_byte(8'h02, 1);
      send_byte(8'h00, 1);
      send_byte(8'h05, 0);
      k = 0;
      while ((total_steps - s0) < 2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("rst_mid_run_step2", total_steps - s0, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstrun_busy", {31'd0, busy}, 32'd0);
      chk("rstrun_strobes", {29'd0, tx_start, dda_step, dda_load}, 32'd0);
      for (int i = 0; i < 10; i++) ref_param[i] = 8'h00;
      ref_v1 = 16'h1234;
      ref_v2 = 16'h8001;
      check_params("rstrun");
      repeat (30) @(negedge clk);
      chk("rstrun_no_more_steps", total_steps - s0, 2);
      chk("rstrun_txcount", tx_q.size(), 0);

      // rx during SEND is dropped
      tx_q.delete();
      send_byte(8'h03, 6);
      chk("send_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h7F, 0);
      wait_idle("send_rx");
      repeat (40) @(negedge clk);
      chk("send_rx_busy", {31'd0, busy}, 32'd0);
      check_tx("send_rx", 4, {ref_v1, ref_v2});

      // Transmitter that never raises busy must not deadlock the frame
      uart_dead = 1'b1;
      cmd_read("deadtx");
      uart_dead = 1'b0;
      repeat (2) @(negedge clk);

      // Randomized command mix
      for (int it = 0; it < 12; it++) begin
         case ($urandom_range(3, 0))
            0: begin
               p = {$urandom(), $urandom(), 16'($urandom())};
               cmd_load(p, 3);
            end
            1: cmd_run(16'($urandom_range(6, 0)), 3);
            2: cmd_read("rread");
            default: begin
               op = 8'($urandom_range(255, 0));
               while (op == 8'h01 || op == 8'h02 || op == 8'h03) op = 8'($urandom_range(255, 0));
               cmd_bad(op);
            end
         endcase
         repeat ($urandom_range(4, 0)) @(negedge clk);
      end

      chk("protocol_violations", n_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
